// File: rtl/j4_io_resp.sv
// j4_io_resp: I/O responder for the J4 core.
// Per-slot mailbox inboxes, a kill-mask register driving per-slot reset
// requests, slot-id and cycle-counter readback, and optional per-slot
// watchdogs compiled in with the J4_IO_WATCHDOG_EN macro.
module j4_io_resp #(
  parameter int MBOX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  input  logic [1:0]  io_slot,
  output logic [15:0] io_din,
  output logic [3:0]  kill_slot_rq
);

  localparam int PW = $clog2(MBOX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(MBOX_DEPTH);

  // Inbox storage; contents need no reset because the pointers define validity.
  logic [15:0]   mem_q [4][MBOX_DEPTH];
  logic          mem_we;
  logic [1:0]    mem_wslot;
  logic [PW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;

  logic [PW-1:0] rptr_q [4];
  logic [PW-1:0] rptr_d [4];
  logic [PW-1:0] wptr_q [4];
  logic [PW-1:0] wptr_d [4];
  logic [CW-1:0] cnt_q  [4];
  logic [CW-1:0] cnt_d  [4];
  logic [3:0]    ovf_q, ovf_d;
  logic [15:0]   io_din_q, io_din_d;
  logic [15:0]   cyc_q, cyc_d;
  logic [3:0]    kill_q, kill_d;
  logic [3:0]    wd_fire;
  logic [15:0]   status_w [4];

  // A simultaneous read and write executes only the read.
  logic wr_en, hit_push, hit_kill;
  assign wr_en    = io_wr & ~io_rd;
  assign hit_push = wr_en && (io_addr[15:2] == 14'h0400);
  assign hit_kill = wr_en && (io_addr == 16'h2004);

  for (genvar gi = 0; gi < 4; gi++) begin : g_status
    assign status_w[gi] = {9'd0, 4'(cnt_q[gi]), ovf_q[gi],
                           (cnt_q[gi] == DEPTH_C), (cnt_q[gi] != '0)};
  end

`ifdef J4_IO_WATCHDOG_EN
  logic [15:0] wd_q [4];
  logic [15:0] wd_d [4];
  logic        hit_wdld;
  assign hit_wdld = wr_en && (io_addr == 16'h2000);

  // Expiry fires on the 1->0 step unless a reload lands on the same edge.
  always_comb begin
    for (int t = 0; t < 4; t++) begin
      wd_fire[t] = (wd_q[t] == 16'd1) && !(hit_wdld && (io_slot == 2'(t)));
    end
  end

  // Watchdog next state: reload wins, otherwise count down; a kill clears it.
  always_comb begin
    for (int t = 0; t < 4; t++) begin
      if (hit_wdld && (io_slot == 2'(t))) begin
        wd_d[t] = io_dout;
      end else if (wd_q[t] != 16'd0) begin
        wd_d[t] = wd_q[t] - 16'd1;
      end else begin
        wd_d[t] = 16'd0;
      end
      if (kill_d[t]) begin
        wd_d[t] = 16'd0;
      end
    end
  end

  // Watchdog counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < 4; t++) wd_q[t] <= 16'd0;
    end else begin
      for (int t = 0; t < 4; t++) wd_q[t] <= wd_d[t];
    end
  end
`else
  assign wd_fire = 4'b0000;
`endif

  // Kill requests from the mask register and watchdog expiry are merged.
  always_comb begin
    kill_d = wd_fire;
    if (hit_kill) begin
      kill_d = kill_d | io_dout[3:0];
    end
  end

  // Access decode: read mux, inbox pop/push, status clear, kill flush.
  always_comb begin
    io_din_d  = io_din_q;
    ovf_d     = ovf_q;
    cyc_d     = cyc_q + 16'd1;
    mem_we    = 1'b0;
    mem_wslot = io_addr[1:0];
    mem_waddr = wptr_q[io_addr[1:0]];
    mem_wdata = io_dout;
    for (int t = 0; t < 4; t++) begin
      rptr_d[t] = rptr_q[t];
      wptr_d[t] = wptr_q[t];
      cnt_d[t]  = cnt_q[t];
    end

    if (io_rd) begin
      case (io_addr)
        16'h1000: begin
          if (cnt_q[io_slot] != '0) begin
            io_din_d        = mem_q[io_slot][rptr_q[io_slot]];
            rptr_d[io_slot] = rptr_q[io_slot] + PW'(1);
            cnt_d[io_slot]  = cnt_q[io_slot] - CW'(1);
          end else begin
            io_din_d = 16'h0000;
          end
        end
        16'h1004: begin
          io_din_d       = status_w[io_slot];
          ovf_d[io_slot] = 1'b0;
        end
        16'h0800: io_din_d = {14'd0, io_slot};
        16'h0801: io_din_d = cyc_q;
        default:  io_din_d = 16'h0000;
      endcase
    end else if (hit_push) begin
      if (cnt_q[io_addr[1:0]] == DEPTH_C) begin
        ovf_d[io_addr[1:0]] = 1'b1;
      end else begin
        mem_we                = 1'b1;
        wptr_d[io_addr[1:0]] = wptr_q[io_addr[1:0]] + PW'(1);
        cnt_d[io_addr[1:0]]  = cnt_q[io_addr[1:0]] + CW'(1);
      end
    end

    // A killed slot loses its inbox on the same edge its pulse is launched.
    for (int t = 0; t < 4; t++) begin
      if (kill_d[t]) begin
        rptr_d[t] = '0;
        wptr_d[t] = '0;
        cnt_d[t]  = '0;
        ovf_d[t]  = 1'b0;
      end
    end
  end

  // Inbox RAM write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wslot][mem_waddr] <= mem_wdata;
    end
  end

  // Control and data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_din_q <= 16'h0000;
      kill_q   <= 4'b0000;
      ovf_q    <= 4'b0000;
      cyc_q    <= 16'h0000;
      for (int t = 0; t < 4; t++) begin
        rptr_q[t] <= '0;
        wptr_q[t] <= '0;
        cnt_q[t]  <= '0;
      end
    end else begin
      io_din_q <= io_din_d;
      kill_q   <= kill_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
      for (int t = 0; t < 4; t++) begin
        rptr_q[t] <= rptr_d[t];
        wptr_q[t] <= wptr_d[t];
        cnt_q[t]  <= cnt_d[t];
      end
    end
  end

  assign io_din = io_din_q;
  // A reset arriving in the pulse cycle suppresses the pulse, so the core
  // never sees a kill request overlapping its own reset.
  assign kill_slot_rq = kill_q & {4{~reset}};

endmodule

// File: tb/tb_j4_io_resp.sv
// Directed testbench for j4_io_resp (MBOX_DEPTH = 4).
// Status word layout used for expected values:
//   {count[3:0], overflow, full, not_empty} in bits [6:0].
module tb_j4_io_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout;
  logic [1:0]  io_slot;
  logic [15:0] io_din;
  logic [3:0]  kill_slot_rq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] tb_cyc;

`ifdef J4_IO_WATCHDOG_EN
  localparam logic [3:0] WD_PULSE = 4'b0100;
`else
  localparam logic [3:0] WD_PULSE = 4'b0000;
`endif

  j4_io_resp #(.MBOX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_dout(io_dout), .io_slot(io_slot),
    .io_din(io_din), .kill_slot_rq(kill_slot_rq)
  );

  always #5 clk = ~clk;

  // Reference cycle count: clock edges since reset was last released.
  always @(posedge clk) tb_cyc <= reset ? 16'h0000 : tb_cyc + 16'h0001;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] s, input logic [15:0] a, input logic [15:0] d);
    io_wr = 1'b1; io_slot = s; io_addr = a; io_dout = d;
    @(negedge clk);
    io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
    $display("wr slot=%0d addr=%h data=%h", s, a, d);
  endtask

  task automatic rd(input logic [1:0] s, input logic [15:0] a);
    io_rd = 1'b1; io_slot = s; io_addr = a;
    @(negedge clk);
    io_rd = 1'b0; io_addr = 16'h0000;
    $display("rd slot=%0d addr=%h -> %h", s, a, io_din);
  endtask

  task automatic test_reset();
    reset = 1'b1; io_rd = 0; io_wr = 0; io_addr = 0; io_dout = 0; io_slot = 0;
    idle(3);
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL reset_din got=%h exp=%h", io_din, 16'h0000); end
    n_checks++; if (kill_slot_rq !== 4'b0000) begin n_fail++; $display("FAIL reset_kill got=%b exp=%b", kill_slot_rq, 4'b0000); end
    reset = 1'b0;
    idle(1);
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), 16'h1004);
      n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL reset_status%0d got=%h exp=%h", s, io_din, 16'h0000); end
    end
  endtask

  task automatic test_slot_id();
    rd(2'd2, 16'h0800);
    n_checks++; if (io_din !== 16'h0002) begin n_fail++; $display("FAIL slot_id2 got=%h exp=%h", io_din, 16'h0002); end
    rd(2'd3, 16'h0800);
    n_checks++; if (io_din !== 16'h0003) begin n_fail++; $display("FAIL slot_id3 got=%h exp=%h", io_din, 16'h0003); end
    idle(2);
    n_checks++; if (io_din !== 16'h0003) begin n_fail++; $display("FAIL din_hold got=%h exp=%h", io_din, 16'h0003); end
    rd(2'd1, 16'h3000);
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL unmapped_rd got=%h exp=%h", io_din, 16'h0000); end
  endtask

  task automatic test_cycle_counter();
    logic [15:0] exp_c;
    idle(5);
    exp_c = tb_cyc;
    rd(2'd0, 16'h0801);
    n_checks++; if (io_din !== exp_c) begin n_fail++; $display("FAIL cyc_first got=%h exp=%h", io_din, exp_c); end
    rd(2'd0, 16'h0801);
    n_checks++; if (io_din !== exp_c + 16'd1) begin n_fail++; $display("FAIL cyc_next got=%h exp=%h", io_din, exp_c + 16'd1); end
  endtask

  task automatic test_mailbox_roundtrip();
    wr(2'd0, 16'h1002, 16'hBEEF);
    rd(2'd2, 16'h1004);
    n_checks++; if (io_din !== 16'h0009) begin n_fail++; $display("FAIL rt_status1 got=%h exp=%h", io_din, 16'h0009); end
    rd(2'd2, 16'h1000);
    n_checks++; if (io_din !== 16'hBEEF) begin n_fail++; $display("FAIL rt_pop got=%h exp=%h", io_din, 16'hBEEF); end
    idle(1);
    n_checks++; if (io_din !== 16'hBEEF) begin n_fail++; $display("FAIL rt_hold got=%h exp=%h", io_din, 16'hBEEF); end
    rd(2'd2, 16'h1004);
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL rt_status0 got=%h exp=%h", io_din, 16'h0000); end
  endtask

  task automatic test_overflow();
    logic [15:0] vals [5];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    for (int i = 0; i < 5; i++) wr(2'd0, 16'h1001, vals[i]);
    rd(2'd1, 16'h1004);
    n_checks++; if (io_din !== 16'h0027) begin n_fail++; $display("FAIL ovf_status got=%h exp=%h", io_din, 16'h0027); end
    rd(2'd1, 16'h1004);
    n_checks++; if (io_din !== 16'h0023) begin n_fail++; $display("FAIL ovf_cleared got=%h exp=%h", io_din, 16'h0023); end
    for (int i = 0; i < 4; i++) begin
      rd(2'd1, 16'h1000);
      n_checks++; if (io_din !== vals[i]) begin n_fail++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, io_din, vals[i]); end
    end
    rd(2'd1, 16'h1000);
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL ovf_pop_empty got=%h exp=%h", io_din, 16'h0000); end
  endtask

  task automatic test_empty_pop();
    rd(2'd3, 16'h0800);
    rd(2'd3, 16'h1000);
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL empty_pop got=%h exp=%h", io_din, 16'h0000); end
    rd(2'd3, 16'h1004);
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL empty_status got=%h exp=%h", io_din, 16'h0000); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_v [4];
    exp_v = '{16'hA002, 16'hA003, 16'hA004, 16'hA005};
    wr(2'd0, 16'h1001, 16'hA001);
    wr(2'd0, 16'h1001, 16'hA002);
    wr(2'd0, 16'h1001, 16'hA003);
    rd(2'd1, 16'h1000);
    n_checks++; if (io_din !== 16'hA001) begin n_fail++; $display("FAIL b2b_pop0 got=%h exp=%h", io_din, 16'hA001); end
    wr(2'd0, 16'h1001, 16'hA004);
    wr(2'd0, 16'h1001, 16'hA005);
    rd(2'd1, 16'h1004);
    n_checks++; if (io_din !== 16'h0023) begin n_fail++; $display("FAIL b2b_full got=%h exp=%h", io_din, 16'h0023); end
    for (int i = 0; i < 4; i++) begin
      rd(2'd1, 16'h1000);
      n_checks++; if (io_din !== exp_v[i]) begin n_fail++; $display("FAIL b2b_pop%0d got=%h exp=%h", i + 1, io_din, exp_v[i]); end
    end
  endtask

  task automatic test_rd_wr_conflict();
    rd(2'd2, 16'h0800);
    io_rd = 1'b1; io_wr = 1'b1; io_slot = 2'd2; io_addr = 16'h1001; io_dout = 16'hEEEE;
    @(negedge clk);
    io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0000;
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL conflict_rd got=%h exp=%h", io_din, 16'h0000); end
    rd(2'd1, 16'h1004);
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL conflict_nopush got=%h exp=%h", io_din, 16'h0000); end
    io_rd = 1'b1; io_wr = 1'b1; io_slot = 2'd0; io_addr = 16'h2004; io_dout = 16'h000F;
    @(negedge clk);
    io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
    n_checks++; if (kill_slot_rq !== 4'b0000) begin n_fail++; $display("FAIL conflict_nokill got=%b exp=%b", kill_slot_rq, 4'b0000); end
  endtask

  task automatic test_kill();
    wr(2'd3, 16'h1000, 16'hC001);
    wr(2'd3, 16'h1000, 16'hC002);
    wr(2'd3, 16'h1001, 16'hC101);
    rd(2'd0, 16'h1004);
    n_checks++; if (io_din !== 16'h0011) begin n_fail++; $display("FAIL kill_pre_status got=%h exp=%h", io_din, 16'h0011); end
    wr(2'd1, 16'h2004, 16'h0005);
    n_checks++; if (kill_slot_rq !== 4'b0101) begin n_fail++; $display("FAIL kill_pulse got=%b exp=%b", kill_slot_rq, 4'b0101); end
    idle(1);
    n_checks++; if (kill_slot_rq !== 4'b0000) begin n_fail++; $display("FAIL kill_one_cycle got=%b exp=%b", kill_slot_rq, 4'b0000); end
    rd(2'd0, 16'h1004);
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL kill_flushed got=%h exp=%h", io_din, 16'h0000); end
    rd(2'd1, 16'h1004);
    n_checks++; if (io_din !== 16'h0009) begin n_fail++; $display("FAIL kill_spared got=%h exp=%h", io_din, 16'h0009); end
    wr(2'd1, 16'h2004, 16'h0002);
    n_checks++; if (kill_slot_rq !== 4'b0010) begin n_fail++; $display("FAIL selfkill_pulse got=%b exp=%b", kill_slot_rq, 4'b0010); end
    idle(1);
    rd(2'd1, 16'h1004);
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL selfkill_flushed got=%h exp=%h", io_din, 16'h0000); end
  endtask

  task automatic test_watchdog();
    logic [15:0] exp_st, exp_pop;
    exp_st  = (WD_PULSE != 4'b0000) ? 16'h0000 : 16'h0009;
    exp_pop = (WD_PULSE != 4'b0000) ? 16'h0000 : 16'hE201;
    wr(2'd0, 16'h1002, 16'hE201);
    wr(2'd2, 16'h2000, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (kill_slot_rq !== 4'b0000) begin n_fail++; $display("FAIL wd_early%0d got=%b exp=%b", i, kill_slot_rq, 4'b0000); end
      @(negedge clk);
    end
    n_checks++; if (kill_slot_rq !== WD_PULSE) begin n_fail++; $display("FAIL wd_pulse got=%b exp=%b", kill_slot_rq, WD_PULSE); end
    idle(1);
    n_checks++; if (kill_slot_rq !== 4'b0000) begin n_fail++; $display("FAIL wd_pulse_end got=%b exp=%b", kill_slot_rq, 4'b0000); end
    rd(2'd2, 16'h1004);
    n_checks++; if (io_din !== exp_st) begin n_fail++; $display("FAIL wd_flush got=%h exp=%h", io_din, exp_st); end
    rd(2'd2, 16'h1000);
    n_checks++; if (io_din !== exp_pop) begin n_fail++; $display("FAIL wd_pop got=%h exp=%h", io_din, exp_pop); end
    // Reload on the expiry cycle (counter at 1) must suppress the pulse.
    wr(2'd2, 16'h2000, 16'h0003);
    idle(2);
    wr(2'd2, 16'h2000, 16'h0005);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (kill_slot_rq !== 4'b0000) begin n_fail++; $display("FAIL wd_reload%0d got=%b exp=%b", i, kill_slot_rq, 4'b0000); end
      @(negedge clk);
    end
    wr(2'd2, 16'h2000, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (kill_slot_rq !== 4'b0000) begin n_fail++; $display("FAIL wd_disabled%0d got=%b exp=%b", i, kill_slot_rq, 4'b0000); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_kill();
    wr(2'd0, 16'h1000, 16'hD001);
    wr(2'd0, 16'h1002, 16'hD002);
    rd(2'd3, 16'h0800);
    io_wr = 1'b1; io_slot = 2'd0; io_addr = 16'h2004; io_dout = 16'h000F;
    @(negedge clk);
    io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
    reset = 1'b1;
    #1;
    n_checks++; if (kill_slot_rq !== 4'b0000) begin n_fail++; $display("FAIL rstkill_pulse got=%b exp=%b", kill_slot_rq, 4'b0000); end
    @(negedge clk);
    n_checks++; if (kill_slot_rq !== 4'b0000) begin n_fail++; $display("FAIL rstkill_held got=%b exp=%b", kill_slot_rq, 4'b0000); end
    n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL rstkill_din got=%h exp=%h", io_din, 16'h0000); end
    reset = 1'b0;
    idle(1);
    n_checks++; if (kill_slot_rq !== 4'b0000) begin n_fail++; $display("FAIL rstkill_after got=%b exp=%b", kill_slot_rq, 4'b0000); end
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), 16'h1004);
      n_checks++; if (io_din !== 16'h0000) begin n_fail++; $display("FAIL rstkill_status%0d got=%h exp=%h", s, io_din, 16'h0000); end
    end
  endtask

  initial begin
    test_reset();
    test_slot_id();
    test_cycle_counter();
    test_mailbox_roundtrip();
    test_overflow();
    test_empty_pop();
    test_back_to_back();
    test_rd_wr_conflict();
    test_kill();
    test_watchdog();
    test_reset_kill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
